// File: rtl/fft_pkg.sv
`default_nettype none
// fft_pkg: shared complex sample type, Q1.15 constants and 16-bit saturation for the FFT/IFFT butterflies.
// Rev 1.0
package fft_pkg;

  localparam int Q_FRAC   = 15;
  localparam int SAT_IN_W = 36;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [15:0] val;
    logic               ovf;
  } sat_t;

  // Clamp a wide signed intermediate to Q1.15 and flag whether clamping happened.
  function automatic sat_t sat16(input logic signed [SAT_IN_W-1:0] x);
    sat_t r;
    r.val = x[15:0];
    r.ovf = 1'b0;
    if (x > SAT_IN_W'(SAT_MAX)) begin
      r.val = SAT_MAX;
      r.ovf = 1'b1;
    end else if (x < SAT_IN_W'(SAT_MIN)) begin
      r.val = SAT_MIN;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmul_conj_pipe.sv
`default_nettype none
// cmul_conj_pipe: registered partial products of diff * conj(W); the pairs are combined downstream.
// Rev 1.0
module cmul_conj_pipe #(
  parameter int DW = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic signed [DW:0]  i_dr,
  input  logic signed [DW:0]  i_di,
  input  logic signed [DW-1:0] i_wr,
  input  logic signed [DW-1:0] i_wi,
  output logic signed [2*DW:0] o_p_rr,
  output logic signed [2*DW:0] o_p_ii,
  output logic signed [2*DW:0] o_p_ir,
  output logic signed [2*DW:0] o_p_ri
);

  localparam int c_PW = 2*DW + 1;

  logic signed [c_PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic signed [c_PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;

  // Operands widened first so the full (DW+1)x(DW) product is kept.
  always_comb begin
    p_rr_d = c_PW'(i_dr) * c_PW'(i_wr);
    p_ii_d = c_PW'(i_di) * c_PW'(i_wi);
    p_ir_d = c_PW'(i_di) * c_PW'(i_wr);
    p_ri_d = c_PW'(i_dr) * c_PW'(i_wi);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
    end else if (i_en) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ir_q <= p_ir_d;
      p_ri_q <= p_ri_d;
    end
  end

  assign o_p_rr = p_rr_q;
  assign o_p_ii = p_ii_q;
  assign o_p_ir = p_ir_q;
  assign o_p_ri = p_ri_q;

endmodule
`default_nettype wire

// File: rtl/ifft_butterfly.sv
`default_nettype none
// ifft_butterfly: 3-stage radix-2 DIF inverse butterfly, A'=(A+B)>>S, B'=((A-B)*conj(W))>>S, valid/ready.
// Rev 1.0
module ifft_butterfly
  import fft_pkg::*;
#(
  parameter int SCALE = 1,
  parameter int DW    = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2*DW-1:0] i_a,
  input  logic [2*DW-1:0] i_b,
  input  logic [2*DW-1:0] i_w,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [2*DW-1:0] o_a,
  output logic [2*DW-1:0] o_b,
  output logic            o_ovf
);

  localparam int c_SW = DW + 1;
  localparam int c_PW = 2*DW + 1;
  localparam int c_XW = SAT_IN_W;
  localparam logic signed [c_XW-1:0] c_RND_A = c_XW'((1 << SCALE) >> 1);
  localparam logic signed [c_XW-1:0] c_RND_B = c_XW'(64'sd1 <<< (Q_FRAC - 1 + SCALE));

  logic  w_en;
  cplx_t w_a, w_b, w_w;

  logic signed [c_SW-1:0] s1_sum_re_d, s1_sum_im_d, s1_dif_re_d, s1_dif_im_d;
  logic                   s1_valid_q;
  logic signed [c_SW-1:0] s1_sum_re_q, s1_sum_im_q, s1_dif_re_q, s1_dif_im_q;
  logic signed [DW-1:0]   s1_w_re_q, s1_w_im_q;

  logic                   s2_valid_q;
  logic signed [c_SW-1:0] s2_sum_re_q, s2_sum_im_q;
  logic signed [c_PW-1:0] w_p_rr, w_p_ii, w_p_ir, w_p_ri;

  logic signed [c_XW-1:0] w_pr, w_pi, w_ar_x, w_ai_x, w_br_x, w_bi_x;
  sat_t                   w_sat_ar, w_sat_ai, w_sat_br, w_sat_bi;
  cplx_t                  s3_a_d, s3_b_d, s3_a_q, s3_b_q;
  logic                   s3_ovf_d, s3_ovf_q, s3_valid_q;

  // The whole pipe advances together; an empty output slot or a taking sink frees it.
  assign w_en    = !s3_valid_q | i_ready;
  assign o_ready = w_en;

  assign w_a = cplx_t'(i_a);
  assign w_b = cplx_t'(i_b);
  assign w_w = cplx_t'(i_w);

  always_comb begin
    s1_sum_re_d = c_SW'(w_a.re) + c_SW'(w_b.re);
    s1_sum_im_d = c_SW'(w_a.im) + c_SW'(w_b.im);
    s1_dif_re_d = c_SW'(w_a.re) - c_SW'(w_b.re);
    s1_dif_im_d = c_SW'(w_a.im) - c_SW'(w_b.im);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_re_q <= '0;
      s1_sum_im_q <= '0;
      s1_dif_re_q <= '0;
      s1_dif_im_q <= '0;
      s1_w_re_q   <= '0;
      s1_w_im_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sum_re_q <= '0;
      s2_sum_im_q <= '0;
    end else if (w_en) begin
      s1_valid_q  <= i_valid;
      s1_sum_re_q <= s1_sum_re_d;
      s1_sum_im_q <= s1_sum_im_d;
      s1_dif_re_q <= s1_dif_re_d;
      s1_dif_im_q <= s1_dif_im_d;
      s1_w_re_q   <= w_w.re;
      s1_w_im_q   <= w_w.im;
      s2_valid_q  <= s1_valid_q;
      s2_sum_re_q <= s1_sum_re_q;
      s2_sum_im_q <= s1_sum_im_q;
    end
  end

  cmul_conj_pipe #(
    .DW (DW)
  ) u_cmul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en),
    .i_dr    (s1_dif_re_q),
    .i_di    (s1_dif_im_q),
    .i_wr    (s1_w_re_q),
    .i_wi    (s1_w_im_q),
    .o_p_rr  (w_p_rr),
    .o_p_ii  (w_p_ii),
    .o_p_ir  (w_p_ir),
    .o_p_ri  (w_p_ri)
  );

  // Round-half-up by adding half an LSB of the target before the arithmetic shift.
  always_comb begin
    w_pr     = c_XW'(w_p_rr) + c_XW'(w_p_ii);
    w_pi     = c_XW'(w_p_ir) - c_XW'(w_p_ri);
    w_ar_x   = (c_XW'(s2_sum_re_q) + c_RND_A) >>> SCALE;
    w_ai_x   = (c_XW'(s2_sum_im_q) + c_RND_A) >>> SCALE;
    w_br_x   = (w_pr + c_RND_B) >>> (Q_FRAC + SCALE);
    w_bi_x   = (w_pi + c_RND_B) >>> (Q_FRAC + SCALE);
    w_sat_ar = sat16(w_ar_x);
    w_sat_ai = sat16(w_ai_x);
    w_sat_br = sat16(w_br_x);
    w_sat_bi = sat16(w_bi_x);
    s3_a_d   = '{re: w_sat_ar.val, im: w_sat_ai.val};
    s3_b_d   = '{re: w_sat_br.val, im: w_sat_bi.val};
    s3_ovf_d = w_sat_ar.ovf | w_sat_ai.ovf | w_sat_br.ovf | w_sat_bi.ovf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s3_valid_q <= 1'b0;
      s3_a_q     <= '0;
      s3_b_q     <= '0;
      s3_ovf_q   <= 1'b0;
    end else if (w_en) begin
      s3_valid_q <= s2_valid_q;
      s3_a_q     <= s3_a_d;
      s3_b_q     <= s3_b_d;
      s3_ovf_q   <= s3_ovf_d;
    end
  end

  assign o_valid = s3_valid_q;
  assign o_a     = s3_a_q;
  assign o_b     = s3_b_q;
  assign o_ovf   = s3_ovf_q;

endmodule
`default_nettype wire
